prediction_reader: RTL and testbench

Read side of the branch-predictor tables, the counterpart of `prediction_writer`. In the IF stage it takes the raw table read data for a branch slot and forwards any same-cycle port-2 write to that slot. It then picks the most trustworthy of the three predictors (SP, LHP, GHP) and drives the final taken/not-taken prediction. It carries every value the writer later needs (`*_id`, `*_ex`) through stall-aware ID and EX pipeline registers.

---
 rtl/prediction_reader_pkg.sv | 16 +
 rtl/predictor_forward.sv | 41 ++++
 rtl/prediction_reader.sv | 256 +++++++++++++++++++++++++
 tb/tb_prediction_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prediction_reader_pkg.sv
// Shared definitions for the branch-predictor table read/write blocks:
// predictor select encodings and default counter widths.
package prediction_reader_pkg;

  localparam int unsigned JW_DEFAULT = 2;
  localparam int unsigned SW_DEFAULT = 5;
  localparam int unsigned TREND_W    = 3;
  localparam int unsigned ADDR_W     = 3;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_SP  = 2'b00;
  localparam sel_t SEL_LHP = 2'b01;
  localparam sel_t SEL_GHP = 2'b10;

endpackage

// File: rtl/predictor_forward.sv
// Same-cycle write-port bypass for one predictor's stat and trend table entries.
module predictor_forward
  import prediction_reader_pkg::*;
#(
  parameter int unsigned IW = 1,
  parameter int unsigned SW = SW_DEFAULT
) (
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [IW-1:0]      i_index,
  input  logic [SW-1:0]      i_t_stat,
  input  logic [TREND_W-1:0] i_t_trend,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [IW-1:0]      i_wr_index,
  input  logic               i_stat_en,
  input  logic [SW-1:0]      i_stat_count,
  input  logic               i_trend_en,
  input  logic [TREND_W-1:0] i_trend_count,
  input  logic               i_clear_en,
  output logic [SW-1:0]      o_stat,
  output logic [TREND_W-1:0] o_trend
);

  logic w_addr_hit;
  logic w_hit;

  assign w_addr_hit = (i_wr_addr == i_addr);
  assign w_hit      = w_addr_hit && (i_wr_index == i_index);

  // A slot clear zeroes every stat for the address, whatever the index.
  always_comb begin
    o_stat = i_t_stat;
    if (i_clear_en && w_addr_hit) begin
      o_stat = '0;
    end else if (w_hit && i_stat_en) begin
      o_stat = i_stat_count;
    end
  end

  assign o_trend = (w_hit && i_trend_en) ? i_trend_count : i_t_trend;

endmodule

// File: rtl/prediction_reader.sv
// Branch-predictor read side: forwards pending writes, selects the best predictor
// and carries the writer's operands through stall-aware ID/EX registers.
module prediction_reader
  import prediction_reader_pkg::*;
#(
  parameter int unsigned JUMP_STATUS_COUNTER_WIDTH = JW_DEFAULT,
  parameter int unsigned STAT_COUNTER_WIDTH        = SW_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 PL_flush,
  input  logic                                 rd_en,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic                                 T_SP_result,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] T_LHP_count,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] T_GHP_count,
  input  logic [STAT_COUNTER_WIDTH-1:0]        T_SP_stat,
  input  logic [STAT_COUNTER_WIDTH-1:0]        T_LHP_stat,
  input  logic [STAT_COUNTER_WIDTH-1:0]        T_GHP_stat,
  input  logic [TREND_W-1:0]                   T_SP_trend,
  input  logic [TREND_W-1:0]                   T_LHP_trend,
  input  logic [TREND_W-1:0]                   T_GHP_trend,
  input  logic [ADDR_W-1:0]                    WR_addr2,
  input  logic                                 WR_SP_index2,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_LHP_index2,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_GHP_index2,
  input  logic                                 WR_SP_stat_en2,
  input  logic                                 WR_LHP_stat_en2,
  input  logic                                 WR_GHP_stat_en2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count2,
  input  logic                                 WR_SP_trend_en2,
  input  logic                                 WR_LHP_trend_en2,
  input  logic                                 WR_GHP_trend_en2,
  input  logic [TREND_W-1:0]                   WR_SP_trend_count2,
  input  logic [TREND_W-1:0]                   WR_LHP_trend_count2,
  input  logic [TREND_W-1:0]                   WR_GHP_trend_count2,
  input  logic                                 clear_en2,
  output logic                                 prediction,
  output logic [1:0]                           sel,
  output logic                                 SP_prediction_result,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count,
  output logic [TREND_W-1:0]                   SP_trend_count,
  output logic [TREND_W-1:0]                   LHP_trend_count,
  output logic [TREND_W-1:0]                   GHP_trend_count,
  output logic [ADDR_W-1:0]                    addr_id,
  output logic                                 SP_prediction_result_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_id,
  output logic                                 prediction_id,
  output logic [1:0]                           sel_id,
  output logic                                 valid_id,
  output logic [ADDR_W-1:0]                    addr_ex,
  output logic                                 SP_prediction_result_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_ex,
  output logic                                 prediction_ex,
  output logic [1:0]                           sel_ex,
  output logic                                 valid_ex
);

  localparam int unsigned JW = JUMP_STATUS_COUNTER_WIDTH;
  localparam int unsigned SW = STAT_COUNTER_WIDTH;

  logic [SW-1:0]      w_sp_stat, w_lhp_stat, w_ghp_stat;
  logic [TREND_W-1:0] w_sp_trend, w_lhp_trend, w_ghp_trend;
  sel_t               w_sel;
  logic               w_pred_bit;
  logic               w_pred;
  logic [SW-1:0]      w_best_stat;
  logic [TREND_W-1:0] w_best_trend;

  predictor_forward #(.IW(1), .SW(SW)) u_fwd_sp (
    .i_addr        (addr),
    .i_index       (T_SP_result),
    .i_t_stat      (T_SP_stat),
    .i_t_trend     (T_SP_trend),
    .i_wr_addr     (WR_addr2),
    .i_wr_index    (WR_SP_index2),
    .i_stat_en     (WR_SP_stat_en2),
    .i_stat_count  (WR_SP_stat_count2),
    .i_trend_en    (WR_SP_trend_en2),
    .i_trend_count (WR_SP_trend_count2),
    .i_clear_en    (clear_en2),
    .o_stat        (w_sp_stat),
    .o_trend       (w_sp_trend)
  );

  predictor_forward #(.IW(JW), .SW(SW)) u_fwd_lhp (
    .i_addr        (addr),
    .i_index       (T_LHP_count),
    .i_t_stat      (T_LHP_stat),
    .i_t_trend     (T_LHP_trend),
    .i_wr_addr     (WR_addr2),
    .i_wr_index    (WR_LHP_index2),
    .i_stat_en     (WR_LHP_stat_en2),
    .i_stat_count  (WR_LHP_stat_count2),
    .i_trend_en    (WR_LHP_trend_en2),
    .i_trend_count (WR_LHP_trend_count2),
    .i_clear_en    (clear_en2),
    .o_stat        (w_lhp_stat),
    .o_trend       (w_lhp_trend)
  );

  predictor_forward #(.IW(JW), .SW(SW)) u_fwd_ghp (
    .i_addr        (addr),
    .i_index       (T_GHP_count),
    .i_t_stat      (T_GHP_stat),
    .i_t_trend     (T_GHP_trend),
    .i_wr_addr     (WR_addr2),
    .i_wr_index    (WR_GHP_index2),
    .i_stat_en     (WR_GHP_stat_en2),
    .i_stat_count  (WR_GHP_stat_count2),
    .i_trend_en    (WR_GHP_trend_en2),
    .i_trend_count (WR_GHP_trend_count2),
    .i_clear_en    (clear_en2),
    .o_stat        (w_ghp_stat),
    .o_trend       (w_ghp_trend)
  );

  // Strictly better: higher signed stat, then higher unsigned trend.
  function automatic logic beats(input logic [SW-1:0] stat_a, input logic [TREND_W-1:0] trend_a,
                                 input logic [SW-1:0] stat_b, input logic [TREND_W-1:0] trend_b);
    if ($signed(stat_a) != $signed(stat_b)) begin
      return $signed(stat_a) > $signed(stat_b);
    end
    return trend_a > trend_b;
  endfunction

  // Start from GHP and only move on a strict win so ties keep GHP > LHP > SP.
  always_comb begin
    w_sel        = SEL_GHP;
    w_best_stat  = w_ghp_stat;
    w_best_trend = w_ghp_trend;
    if (beats(w_lhp_stat, w_lhp_trend, w_best_stat, w_best_trend)) begin
      w_sel        = SEL_LHP;
      w_best_stat  = w_lhp_stat;
      w_best_trend = w_lhp_trend;
    end
    if (beats(w_sp_stat, w_sp_trend, w_best_stat, w_best_trend)) begin
      w_sel = SEL_SP;
    end
  end

  always_comb begin
    w_pred_bit = T_GHP_count[JW-1];
    unique case (w_sel)
      SEL_SP:  w_pred_bit = T_SP_result;
      SEL_LHP: w_pred_bit = T_LHP_count[JW-1];
      default: w_pred_bit = T_GHP_count[JW-1];
    endcase
  end

  assign w_pred = rd_en & w_pred_bit;

  assign prediction           = w_pred;
  assign sel                  = w_sel;
  assign SP_prediction_result = T_SP_result;
  assign LHP_count            = T_LHP_count;
  assign GHP_count            = T_GHP_count;
  assign SP_stat_count        = w_sp_stat;
  assign LHP_stat_count       = w_lhp_stat;
  assign GHP_stat_count       = w_ghp_stat;
  assign SP_trend_count       = w_sp_trend;
  assign LHP_trend_count      = w_lhp_trend;
  assign GHP_trend_count      = w_ghp_trend;

  logic [ADDR_W-1:0] r_addr_id, r_addr_ex;
  logic              r_spr_id, r_spr_ex;
  logic [JW-1:0]     r_lhpc_id, r_lhpc_ex, r_ghpc_id, r_ghpc_ex;
  logic [SW-1:0]     r_sps_id, r_sps_ex, r_lhps_id, r_lhps_ex, r_ghps_id, r_ghps_ex;
  logic              r_pred_id, r_pred_ex;
  sel_t              r_sel_id, r_sel_ex;
  logic              r_valid_id, r_valid_ex;

  // Flush advances the pipe even under stall, killing the entry entering ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_id  <= '0;
      r_spr_id   <= 1'b0;
      r_lhpc_id  <= '0;
      r_ghpc_id  <= '0;
      r_sps_id   <= '0;
      r_lhps_id  <= '0;
      r_ghps_id  <= '0;
      r_pred_id  <= 1'b0;
      r_sel_id   <= SEL_SP;
      r_valid_id <= 1'b0;
      r_addr_ex  <= '0;
      r_spr_ex   <= 1'b0;
      r_lhpc_ex  <= '0;
      r_ghpc_ex  <= '0;
      r_sps_ex   <= '0;
      r_lhps_ex  <= '0;
      r_ghps_ex  <= '0;
      r_pred_ex  <= 1'b0;
      r_sel_ex   <= SEL_SP;
      r_valid_ex <= 1'b0;
    end else if (PL_flush || !PL_stall) begin
      r_addr_id  <= addr;
      r_spr_id   <= T_SP_result;
      r_lhpc_id  <= T_LHP_count;
      r_ghpc_id  <= T_GHP_count;
      r_sps_id   <= w_sp_stat;
      r_lhps_id  <= w_lhp_stat;
      r_ghps_id  <= w_ghp_stat;
      r_pred_id  <= w_pred;
      r_sel_id   <= w_sel;
      r_valid_id <= rd_en && !PL_flush;
      r_addr_ex  <= r_addr_id;
      r_spr_ex   <= r_spr_id;
      r_lhpc_ex  <= r_lhpc_id;
      r_ghpc_ex  <= r_ghpc_id;
      r_sps_ex   <= r_sps_id;
      r_lhps_ex  <= r_lhps_id;
      r_ghps_ex  <= r_ghps_id;
      r_pred_ex  <= r_pred_id;
      r_sel_ex   <= r_sel_id;
      r_valid_ex <= r_valid_id;
    end
  end

  assign addr_id                 = r_addr_id;
  assign SP_prediction_result_id = r_spr_id;
  assign LHP_count_id            = r_lhpc_id;
  assign GHP_count_id            = r_ghpc_id;
  assign SP_stat_count_id        = r_sps_id;
  assign LHP_stat_count_id       = r_lhps_id;
  assign GHP_stat_count_id       = r_ghps_id;
  assign prediction_id           = r_pred_id;
  assign sel_id                  = r_sel_id;
  assign valid_id                = r_valid_id;
  assign addr_ex                 = r_addr_ex;
  assign SP_prediction_result_ex = r_spr_ex;
  assign LHP_count_ex            = r_lhpc_ex;
  assign GHP_count_ex            = r_ghpc_ex;
  assign SP_stat_count_ex        = r_sps_ex;
  assign LHP_stat_count_ex       = r_lhps_ex;
  assign GHP_stat_count_ex       = r_ghps_ex;
  assign prediction_ex           = r_pred_ex;
  assign sel_ex                  = r_sel_ex;
  assign valid_ex                = r_valid_ex;

endmodule

// File: tb/tb_prediction_reader.sv
// Scoreboard bench for prediction_reader: directed vectors queue expectations
// stamped with the cycle they are due; a negedge monitor checks them.
module tb_prediction_reader;

  logic clk = 1'b0;
  logic rst_n, PL_stall, PL_flush, rd_en;
  logic [2:0] addr;
  logic T_SP_result;
  logic [1:0] T_LHP_count, T_GHP_count;
  logic [4:0] T_SP_stat, T_LHP_stat, T_GHP_stat;
  logic [2:0] T_SP_trend, T_LHP_trend, T_GHP_trend;
  logic [2:0] WR_addr2;
  logic WR_SP_index2;
  logic [1:0] WR_LHP_index2, WR_GHP_index2;
  logic WR_SP_stat_en2, WR_LHP_stat_en2, WR_GHP_stat_en2;
  logic [4:0] WR_SP_stat_count2, WR_LHP_stat_count2, WR_GHP_stat_count2;
  logic WR_SP_trend_en2, WR_LHP_trend_en2, WR_GHP_trend_en2;
  logic [2:0] WR_SP_trend_count2, WR_LHP_trend_count2, WR_GHP_trend_count2;
  logic clear_en2;

  logic prediction, SP_prediction_result;
  logic [1:0] sel, LHP_count, GHP_count;
  logic [4:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
  logic [2:0] SP_trend_count, LHP_trend_count, GHP_trend_count;
  logic [2:0] addr_id, addr_ex;
  logic SP_prediction_result_id, SP_prediction_result_ex;
  logic [1:0] LHP_count_id, GHP_count_id, LHP_count_ex, GHP_count_ex;
  logic [4:0] SP_stat_count_id, LHP_stat_count_id, GHP_stat_count_id;
  logic [4:0] SP_stat_count_ex, LHP_stat_count_ex, GHP_stat_count_ex;
  logic prediction_id, prediction_ex, valid_id, valid_ex;
  logic [1:0] sel_id, sel_ex;

  prediction_reader #(.JUMP_STATUS_COUNTER_WIDTH(2), .STAT_COUNTER_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .PL_flush(PL_flush), .rd_en(rd_en),
    .addr(addr), .T_SP_result(T_SP_result), .T_LHP_count(T_LHP_count),
    .T_GHP_count(T_GHP_count), .T_SP_stat(T_SP_stat), .T_LHP_stat(T_LHP_stat),
    .T_GHP_stat(T_GHP_stat), .T_SP_trend(T_SP_trend), .T_LHP_trend(T_LHP_trend),
    .T_GHP_trend(T_GHP_trend), .WR_addr2(WR_addr2), .WR_SP_index2(WR_SP_index2),
    .WR_LHP_index2(WR_LHP_index2), .WR_GHP_index2(WR_GHP_index2),
    .WR_SP_stat_en2(WR_SP_stat_en2), .WR_LHP_stat_en2(WR_LHP_stat_en2),
    .WR_GHP_stat_en2(WR_GHP_stat_en2), .WR_SP_stat_count2(WR_SP_stat_count2),
    .WR_LHP_stat_count2(WR_LHP_stat_count2), .WR_GHP_stat_count2(WR_GHP_stat_count2),
    .WR_SP_trend_en2(WR_SP_trend_en2), .WR_LHP_trend_en2(WR_LHP_trend_en2),
    .WR_GHP_trend_en2(WR_GHP_trend_en2), .WR_SP_trend_count2(WR_SP_trend_count2),
    .WR_LHP_trend_count2(WR_LHP_trend_count2), .WR_GHP_trend_count2(WR_GHP_trend_count2),
    .clear_en2(clear_en2), .prediction(prediction), .sel(sel),
    .SP_prediction_result(SP_prediction_result), .LHP_count(LHP_count),
    .GHP_count(GHP_count), .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count),
    .GHP_stat_count(GHP_stat_count), .SP_trend_count(SP_trend_count),
    .LHP_trend_count(LHP_trend_count), .GHP_trend_count(GHP_trend_count),
    .addr_id(addr_id), .SP_prediction_result_id(SP_prediction_result_id),
    .LHP_count_id(LHP_count_id), .GHP_count_id(GHP_count_id),
    .SP_stat_count_id(SP_stat_count_id), .LHP_stat_count_id(LHP_stat_count_id),
    .GHP_stat_count_id(GHP_stat_count_id), .prediction_id(prediction_id),
    .sel_id(sel_id), .valid_id(valid_id), .addr_ex(addr_ex),
    .SP_prediction_result_ex(SP_prediction_result_ex), .LHP_count_ex(LHP_count_ex),
    .GHP_count_ex(GHP_count_ex), .SP_stat_count_ex(SP_stat_count_ex),
    .LHP_stat_count_ex(LHP_stat_count_ex), .GHP_stat_count_ex(GHP_stat_count_ex),
    .prediction_ex(prediction_ex), .sel_ex(sel_ex), .valid_ex(valid_ex)
  );

  always #5 clk = ~clk;

  localparam int K_PRED = 0, K_SEL = 1, K_SP_ST = 2, K_LHP_ST = 3, K_GHP_ST = 4;
  localparam int K_LHP_TR = 5, K_ADDR_ID = 6, K_VALID_ID = 7, K_SEL_ID = 8, K_PRED_ID = 9;
  localparam int K_ADDR_EX = 10, K_VALID_EX = 11, K_SEL_EX = 12, K_PRED_EX = 13;
  localparam int K_GHP_ST_ID = 14, K_GHP_ST_EX = 15, K_LHPC_ID = 16, K_SPR_EX = 17;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int k);
    case (k)
      K_PRED:      return 32'(prediction);
      K_SEL:       return 32'(sel);
      K_SP_ST:     return 32'(SP_stat_count);
      K_LHP_ST:    return 32'(LHP_stat_count);
      K_GHP_ST:    return 32'(GHP_stat_count);
      K_LHP_TR:    return 32'(LHP_trend_count);
      K_ADDR_ID:   return 32'(addr_id);
      K_VALID_ID:  return 32'(valid_id);
      K_SEL_ID:    return 32'(sel_id);
      K_PRED_ID:   return 32'(prediction_id);
      K_ADDR_EX:   return 32'(addr_ex);
      K_VALID_EX:  return 32'(valid_ex);
      K_SEL_EX:    return 32'(sel_ex);
      K_PRED_EX:   return 32'(prediction_ex);
      K_GHP_ST_ID: return 32'(GHP_stat_count_id);
      K_GHP_ST_EX: return 32'(GHP_stat_count_ex);
      K_LHPC_ID:   return 32'(LHP_count_id);
      K_SPR_EX:    return 32'(SP_prediction_result_ex);
      default:     return 32'hdeadbeef;
    endcase
  endfunction

  task automatic chk(input int dly, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due this cycle; stale ones are misses.
  always @(negedge clk) begin
    int i;
    logic [31:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        got = dut_val(sb[i].kind);
        n_vec++;
        if (sb[i].cyc != cyc || got !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s (cyc %0d): got %0h, expected %0h", sb[i].name, cyc, got,
                   sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic clr();
    PL_stall = 0; PL_flush = 0; rd_en = 0; addr = 0; T_SP_result = 0;
    T_LHP_count = 0; T_GHP_count = 0; T_SP_stat = 0; T_LHP_stat = 0; T_GHP_stat = 0;
    T_SP_trend = 0; T_LHP_trend = 0; T_GHP_trend = 0; WR_addr2 = 0; WR_SP_index2 = 0;
    WR_LHP_index2 = 0; WR_GHP_index2 = 0; WR_SP_stat_en2 = 0; WR_LHP_stat_en2 = 0;
    WR_GHP_stat_en2 = 0; WR_SP_stat_count2 = 0; WR_LHP_stat_count2 = 0;
    WR_GHP_stat_count2 = 0; WR_SP_trend_en2 = 0; WR_LHP_trend_en2 = 0;
    WR_GHP_trend_en2 = 0; WR_SP_trend_count2 = 0; WR_LHP_trend_count2 = 0;
    WR_GHP_trend_count2 = 0; clear_en2 = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic vec_sel_by_stat();
    rd_en = 1; addr = 5; T_SP_result = 1;
    T_SP_stat = 5'd3; T_LHP_stat = 5'b11110; T_GHP_stat = 5'd1;
  endtask

  initial begin
    rst_n = 0;
    clr();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(0, K_VALID_ID, 0, "reset valid_id");
    chk(0, K_VALID_EX, 0, "reset valid_ex");
    chk(0, K_ADDR_ID, 0, "reset addr_id");
    chk(0, K_SEL_EX, 0, "reset sel_ex");
    rst_n = 1;

    next(); vec_sel_by_stat();
    chk(0, K_SEL, 0, "stat sel");
    chk(0, K_PRED, 1, "stat pred");
    chk(0, K_SP_ST, 3, "stat sp passthru");
    chk(0, K_LHP_ST, 5'h1e, "stat lhp passthru");
    chk(1, K_ADDR_ID, 5, "addr_id +1");
    chk(1, K_VALID_ID, 1, "valid_id +1");
    chk(1, K_PRED_ID, 1, "pred_id +1");
    chk(1, K_GHP_ST_ID, 1, "ghp_stat_id +1");
    chk(2, K_ADDR_EX, 5, "addr_ex +2");
    chk(2, K_VALID_EX, 1, "valid_ex +2");
    chk(2, K_PRED_EX, 1, "pred_ex +2");
    chk(2, K_SPR_EX, 1, "sp_result_ex +2");
    chk(2, K_GHP_ST_EX, 1, "ghp_stat_ex +2");

    next();
    rd_en = 1; addr = 3; T_LHP_count = 2'b10;
    T_SP_stat = 4; T_LHP_stat = 4; T_GHP_stat = 4;
    T_SP_trend = 2; T_LHP_trend = 6; T_GHP_trend = 5;
    chk(0, K_SEL, 1, "trend tie sel");
    chk(0, K_PRED, 1, "trend tie pred");
    chk(1, K_SEL_ID, 1, "sel_id lhp");
    chk(1, K_LHPC_ID, 2, "lhp_count_id");
    chk(2, K_SEL_EX, 1, "sel_ex lhp");

    next();
    rd_en = 1; addr = 2; T_GHP_count = 2'b11;
    T_SP_stat = 4; T_LHP_stat = 4; T_GHP_stat = 4;
    T_SP_trend = 3; T_LHP_trend = 3; T_GHP_trend = 3;
    chk(0, K_SEL, 2, "full tie sel");
    chk(0, K_PRED, 1, "full tie pred");

    next();
    rd_en = 1; addr = 6; T_GHP_stat = 5'b11000; T_GHP_count = 2'b01;
    WR_addr2 = 6; WR_GHP_index2 = 2'b01; WR_GHP_stat_en2 = 1; WR_GHP_stat_count2 = 5'd7;
    chk(0, K_GHP_ST, 7, "fwd hit stat");
    chk(0, K_SEL, 2, "fwd hit sel");
    chk(0, K_PRED, 0, "fwd hit pred");
    chk(1, K_GHP_ST_ID, 7, "fwd stat to id");

    next();
    rd_en = 1; addr = 6; T_GHP_stat = 5'b11000; T_GHP_count = 2'b01;
    WR_addr2 = 6; WR_GHP_index2 = 2'b10; WR_GHP_stat_en2 = 1; WR_GHP_stat_count2 = 5'd7;
    chk(0, K_GHP_ST, 5'h18, "fwd idx miss stat");
    chk(0, K_SEL, 1, "fwd idx miss sel");

    next();
    rd_en = 1; addr = 4; T_SP_result = 1; T_GHP_count = 2'b10;
    T_SP_stat = 5; T_LHP_stat = 3; T_GHP_stat = 5'b11111;
    WR_addr2 = 4; clear_en2 = 1; WR_SP_index2 = 1; WR_SP_stat_en2 = 1;
    WR_SP_stat_count2 = 5'd9;
    chk(0, K_SP_ST, 0, "clear sp stat");
    chk(0, K_LHP_ST, 0, "clear lhp stat");
    chk(0, K_GHP_ST, 0, "clear ghp stat");
    chk(0, K_SEL, 2, "clear sel");
    chk(0, K_PRED, 1, "clear pred");

    next();
    rd_en = 1; addr = 1; T_SP_trend = 2; T_LHP_trend = 2; T_GHP_trend = 2;
    WR_addr2 = 1; WR_LHP_index2 = 0; WR_LHP_trend_en2 = 1; WR_LHP_trend_count2 = 7;
    chk(0, K_LHP_TR, 7, "fwd trend");
    chk(0, K_SEL, 1, "fwd trend sel");

    next();
    rd_en = 1; T_SP_result = 1; T_SP_stat = 5'b01111; T_LHP_stat = 5'b10000;
    chk(0, K_SEL, 0, "max vs min sel");
    chk(0, K_PRED, 1, "max vs min pred");

    next();
    rd_en = 0; T_SP_result = 1; T_SP_stat = 5'b01111; T_LHP_stat = 5'b10000;
    chk(0, K_PRED, 0, "rd_en=0 pred");
    chk(1, K_VALID_ID, 0, "rd_en=0 valid_id");
    chk(1, K_PRED_ID, 0, "rd_en=0 pred_id");

    next(); rd_en = 1; addr = 3;
    next(); rd_en = 1; addr = 5;
    for (int i = 0; i < 3; i++) begin
      next();
      PL_stall = 1; rd_en = 1; addr = 2;
      chk(0, K_ADDR_ID, 5, "stall addr_id");
      chk(0, K_ADDR_EX, 3, "stall addr_ex");
      chk(0, K_VALID_ID, 1, "stall valid_id");
    end
    next();
    PL_stall = 1; PL_flush = 1; rd_en = 1; addr = 7;
    chk(0, K_ADDR_ID, 5, "stall3 addr_id");
    chk(0, K_ADDR_EX, 3, "stall3 addr_ex");
    chk(1, K_VALID_ID, 0, "flush valid_id");
    chk(1, K_ADDR_EX, 5, "flush addr_ex");
    chk(1, K_VALID_EX, 1, "flush valid_ex");
    next();
    chk(1, K_VALID_EX, 0, "post flush valid_ex");

    for (int i = 0; i < 10; i++) begin
      next();
      rd_en = 1'($urandom); addr = 3'($urandom); T_SP_result = 1'($urandom);
      T_LHP_count = 2'($urandom); T_GHP_count = 2'($urandom);
      T_SP_stat = 5'($urandom); T_LHP_stat = 5'($urandom); T_GHP_stat = 5'($urandom);
      T_SP_trend = 3'($urandom); T_LHP_trend = 3'($urandom); T_GHP_trend = 3'($urandom);
      WR_addr2 = 3'($urandom); WR_GHP_stat_en2 = 1'($urandom);
      WR_GHP_stat_count2 = 5'($urandom); PL_stall = 1'($urandom);
    end
    next();
    rd_en = 1; addr = 6; T_SP_result = 1; T_SP_stat = 5'd9; T_GHP_count = 2'b11;
    next();
    vec_sel_by_stat();
    rst_n = 0; PL_stall = 1; PL_flush = 1;
    chk(0, K_VALID_ID, 1, "pre-reset valid_id");
    chk(0, K_ADDR_ID, 6, "pre-reset addr_id");
    chk(0, K_PRED, 1, "pred during reset");
    chk(0, K_SEL, 0, "sel during reset");
    chk(1, K_VALID_ID, 0, "rst valid_id");
    chk(1, K_VALID_EX, 0, "rst valid_ex");
    chk(1, K_ADDR_ID, 0, "rst addr_id");
    chk(1, K_ADDR_EX, 0, "rst addr_ex");
    chk(1, K_PRED_ID, 0, "rst pred_id");
    chk(1, K_PRED_EX, 0, "rst pred_ex");
    chk(1, K_SEL_ID, 0, "rst sel_id");
    chk(1, K_SEL_EX, 0, "rst sel_ex");
    chk(1, K_GHP_ST_ID, 0, "rst ghp_stat_id");
    next();
    rst_n = 1;
    chk(1, K_VALID_EX, 0, "post rst valid_ex");

    next();
    next();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec += sb.size();
      n_err += sb.size();
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
